uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the async UART receiver. It captures each received byte, qualified by the receiver's data-ready strobe, into a first-word-fall-through FIFO. It tracks occupancy, overflow and complete lines (bytes terminated by EOL_CHAR), and presents a read handshake to the consuming logic (command parser, display, loopback).

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 76 +++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bus between the UART receiver, the receive FIFO and its consumer.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [7:0]            R_Data;
  logic                  Data_ready;
  logic                  rd_en;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full;
  logic                  ovf;
  logic                  ovf_clr;
  logic                  eol_pulse;
  logic [DEPTH_LOG2:0]   line_count;
  logic                  line_avail;

  modport master (
    output R_Data, Data_ready, rd_en, ovf_clr,
    input  rd_data, rd_valid, fifo_count, fifo_full, ovf, eol_pulse, line_count, line_avail
  );

  modport slave (
    input  R_Data, Data_ready, rd_en, ovf_clr,
    output rd_data, rd_valid, fifo_count, fifo_full, ovf, eol_pulse, line_count, line_avail
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with
// overflow flag and complete-line tracking.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  EOL_CHAR   = 8'h0D
) (
  input  logic           CLK_50M,
  input  logic           FPGA_RST,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [PW-1:0] line_cnt;
  logic [7:0]    head_q, head_n;
  logic          data_ready_q;
  logic          ovf_q, eol_q;
  logic          full, empty;
  logic          wr_req, rd_pop, wr_acc, wr_drop, eol_in, eol_out;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  // Write/pop qualification
  always_comb begin
    wr_req   = bus.Data_ready & ~data_ready_q;
    rd_pop   = bus.rd_en & ~empty;
    wr_acc   = wr_req & (~full | rd_pop);
    wr_drop  = wr_req & full & ~rd_pop;
    eol_in   = wr_acc & (bus.R_Data == EOL_CHAR);
    eol_out  = rd_pop & (head_q == EOL_CHAR);
    rd_ptr_n = rd_pop ? rd_ptr + PW'(1) : rd_ptr;
    wr_ptr_n = wr_acc ? wr_ptr + PW'(1) : wr_ptr;
    // A write landing on the next head slot bypasses the memory read.
    if (wr_acc && (rd_ptr_n == wr_ptr)) head_n = bus.R_Data;
    else                                head_n = mem[rd_ptr_n[PW-2:0]];
  end

  always_ff @(posedge CLK_50M) begin
    if (wr_acc) mem[wr_ptr[PW-2:0]] <= bus.R_Data;
  end

  always_ff @(posedge CLK_50M) begin
    if (FPGA_RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      head_q       <= 8'h00;
      data_ready_q <= 1'b0;
      ovf_q        <= 1'b0;
      eol_q        <= 1'b0;
      line_cnt     <= '0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      head_q       <= head_n;
      data_ready_q <= bus.Data_ready;
      eol_q        <= eol_in;
      if (wr_drop)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
      if (eol_in && !eol_out)      line_cnt <= line_cnt + PW'(1);
      else if (!eol_in && eol_out) line_cnt <= line_cnt - PW'(1);
    end
  end

  assign bus.rd_data    = head_q;
  assign bus.rd_valid   = ~empty;
  assign bus.fifo_count = wr_ptr - rd_ptr;
  assign bus.fifo_full  = full;
  assign bus.ovf        = ovf_q;
  assign bus.eol_pulse  = eol_q;
  assign bus.line_count = line_cnt;
  assign bus.line_avail = (line_cnt != '0);
endmodule
